// File: rtl/mem_arbiter.sv
// Serialises the openmips fetch (rom_*) and data (ram_*) ports onto one req/ack memory.
// The data port wins; the core is stalled until every latched access has completed or timed out.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce_i,
    input  logic [ADDR_W-1:0] rom_addr_i,
    output logic [DATA_W-1:0] rom_data_o,
    input  logic              ram_ce_i,
    input  logic              ram_we_i,
    input  logic [ADDR_W-1:0] ram_addr_i,
    input  logic [3:0]        ram_sel_i,
    input  logic [DATA_W-1:0] ram_data_i,
    output logic [DATA_W-1:0] ram_data_o,
    output logic              stallreq_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_sel_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    typedef enum logic [1:0] {
        IDLE,
        D_ACC,
        I_ACC,
        RELEASE
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t              state;
    state_t              state_next;
    logic                d_pend;
    logic                i_pend;
    logic [ADDR_W-1:0]   i_addr;
    logic [7:0]          cnt;
    logic                active;
    logic                ack_hit;
    logic                to_hit;
    logic                done;
    logic [DATA_W-1:0]   capture;

    // Access completion decode; an ack coinciding with the last counter value wins over timeout.
    always_comb begin
        active  = mem_req_o && ((state == D_ACC && d_pend) || (state == I_ACC && i_pend));
        ack_hit = active && mem_ack_i;
        to_hit  = active && !mem_ack_i && (cnt == TO_LAST);
        done    = ack_hit || to_hit;
        capture = to_hit ? '0 : mem_rdata_i;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ram_ce_i)
                    state_next = D_ACC;
                else if (rom_ce_i)
                    state_next = I_ACC;
            end
            D_ACC: begin
                if (done)
                    state_next = i_pend ? I_ACC : RELEASE;
            end
            I_ACC: begin
                if (done)
                    state_next = RELEASE;
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rom_data_o  <= '0;
            ram_data_o  <= '0;
            stallreq_o  <= 1'b0;
            err_o       <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_sel_o   <= '0;
            mem_wdata_o <= '0;
            d_pend      <= 1'b0;
            i_pend      <= 1'b0;
            i_addr      <= '0;
            cnt         <= '0;
        end else begin
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (ram_ce_i || rom_ce_i) begin
                        d_pend     <= ram_ce_i;
                        i_pend     <= rom_ce_i;
                        i_addr     <= rom_addr_i;
                        stallreq_o <= 1'b1;
                        mem_req_o  <= 1'b1;
                        cnt        <= '0;
                        if (ram_ce_i) begin
                            mem_we_o    <= ram_we_i;
                            mem_addr_o  <= ram_addr_i;
                            mem_sel_o   <= ram_sel_i;
                            mem_wdata_o <= ram_data_i;
                        end else begin
                            mem_we_o    <= 1'b0;
                            mem_addr_o  <= rom_addr_i;
                            mem_sel_o   <= '1;
                            mem_wdata_o <= '0;
                        end
                    end
                end
                D_ACC: begin
                    if (done) begin
                        mem_req_o  <= 1'b0;
                        mem_we_o   <= 1'b0;
                        d_pend     <= 1'b0;
                        err_o      <= to_hit;
                        stallreq_o <= i_pend;
                        if (!mem_we_o)
                            ram_data_o <= capture;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                I_ACC: begin
                    // mem_req_o low here only in the turnaround cycle after a data access.
                    if (!mem_req_o) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= i_addr;
                        mem_sel_o   <= '1;
                        mem_wdata_o <= '0;
                        cnt         <= '0;
                    end else if (done) begin
                        mem_req_o  <= 1'b0;
                        rom_data_o <= capture;
                        i_pend     <= 1'b0;
                        err_o      <= to_hit;
                        stallreq_o <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RELEASE: stallreq_o <= 1'b0;
                default: stallreq_o <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected memory requests and core responses are queued
// by the stimulus and popped by a memory responder and a release-cycle monitor.
module tb_mem_arbiter;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] rom;
        logic [31:0] ram;
        int          err_n;
        int          stall_n;
        int          req_n;
    } rsp_t;

    logic        clk;
    logic        rst;
    logic        rom_ce_i;
    logic [31:0] rom_addr_i;
    logic [31:0] rom_data_o;
    logic        ram_ce_i;
    logic        ram_we_i;
    logic [31:0] ram_addr_i;
    logic [3:0]  ram_sel_i;
    logic [31:0] ram_data_i;
    logic [31:0] ram_data_o;
    logic        stallreq_o;
    logic        err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] rdata;
    logic        ack;
    logic        extra_ack;
    logic        mem_ack;

    assign mem_ack = ack | extra_ack;

    int   checks = 0;
    int   errors = 0;
    int   mem_lat = -1;
    req_t req_q[$];
    rsp_t rsp_q[$];

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i), .rom_data_o(rom_data_o),
        .ram_ce_i(ram_ce_i), .ram_we_i(ram_we_i), .ram_addr_i(ram_addr_i),
        .ram_sel_i(ram_sel_i), .ram_data_i(ram_data_i), .ram_data_o(ram_data_o),
        .stallreq_o(stallreq_o), .err_o(err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_sel_o(mem_sel_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(rdata), .mem_ack_i(mem_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        case (a)
            32'h0000_0010: rd = 32'h3401_1100;
            32'h0000_0100: rd = 32'hCAFE_F00D;
            32'h0000_0014: rd = 32'h1234_5678;
            32'h0000_0020: rd = 32'h0BAD_F00D;
            default:       rd = a ^ 32'h5A5A_0000;
        endcase
    endfunction

    // Memory responder: checks each new request against req_q and acks mem_lat cycles later.
    initial begin
        logic prev_req;
        logic run;
        int   k;
        req_t cur;
        ack = 1'b0; rdata = '0; prev_req = 1'b0; run = 1'b0; k = 0;
        cur = '{we: 1'b0, addr: '0, sel: '0, wdata: '0};
        forever begin
            @(posedge clk); #1;
            ack = 1'b0;
            if (mem_req_o !== 1'b1) begin
                run = 1'b0;
            end else if (!prev_req) begin
                if (req_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL memreq_unexpected: got addr %h expected no request", mem_addr_o);
                end else begin
                    cur = req_q.pop_front();
                    chk("memreq_we", {31'd0, mem_we_o}, {31'd0, cur.we});
                    chk("memreq_addr", mem_addr_o, cur.addr);
                    chk("memreq_sel", {28'd0, mem_sel_o}, {28'd0, cur.sel});
                    chk("memreq_wdata", mem_wdata_o, cur.wdata);
                end
                run = 1'b1; k = 0;
            end else if (run) begin
                k++;
            end
            if (run && mem_lat > 0 && k == mem_lat) begin
                chk("hold_we", {31'd0, mem_we_o}, {31'd0, cur.we});
                chk("hold_addr", mem_addr_o, cur.addr);
                chk("hold_sel", {28'd0, mem_sel_o}, {28'd0, cur.sel});
                chk("hold_wdata", mem_wdata_o, cur.wdata);
                rdata = rd(mem_addr_o);
                ack = 1'b1;
                run = 1'b0;
            end
            prev_req = (mem_req_o === 1'b1);
        end
    end

    // Release monitor: on each stall fall compares outputs and cycle counts against rsp_q.
    initial begin
        logic prev_stall;
        int   sc, ec, rc;
        rsp_t e;
        prev_stall = 1'b0; sc = 0; ec = 0; rc = 0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                prev_stall = 1'b0; sc = 0; ec = 0; rc = 0;
            end else begin
                if (stallreq_o === 1'b1) sc++;
                if (err_o === 1'b1) ec++;
                if (mem_req_o === 1'b1) rc++;
                if (prev_stall && stallreq_o !== 1'b1) begin
                    if (rsp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rsp_unexpected: got release with stall %0d expected none", sc);
                    end else begin
                        e = rsp_q.pop_front();
                        chk("rom_data", rom_data_o, e.rom);
                        chk("ram_data", ram_data_o, e.ram);
                        chk("err_pulses", ec, e.err_n);
                        chk("stall_cycles", sc, e.stall_n);
                        chk("req_cycles", rc, e.req_n);
                    end
                    sc = 0; ec = 0; rc = 0;
                end
                prev_stall = (stallreq_o === 1'b1);
            end
        end
    end

    task automatic access(input bit d, input bit we, input logic [31:0] daddr,
                          input logic [3:0] sel, input logic [31:0] wd,
                          input bit i, input logic [31:0] iaddr, input int lat);
        int c;
        mem_lat = lat;
        ram_ce_i = d; ram_we_i = we; ram_addr_i = daddr; ram_sel_i = sel; ram_data_i = wd;
        rom_ce_i = i; rom_addr_i = iaddr;
        c = 0;
        while (rsp_q.size() != 0 && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (rsp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending responses expected 0", rsp_q.size());
            rsp_q.delete();
        end
        chk("req_q_empty", req_q.size(), 0);
        @(posedge clk); #1;
        ram_ce_i = 1'b0; rom_ce_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rom"}, rom_data_o, 32'h0);
        chk({tag, "_ram"}, ram_data_o, 32'h0);
        chk({tag, "_ctl"}, {27'd0, stallreq_o, err_o, mem_req_o, mem_we_o, 1'b0},
            32'h0);
        chk({tag, "_memf"}, {28'd0, mem_sel_o} | mem_addr_o | mem_wdata_o, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; extra_ack = 1'b0;
        rom_ce_i = 1'b0; rom_addr_i = '0;
        ram_ce_i = 1'b1; ram_we_i = 1'b0; ram_addr_i = 32'h0000_0100;
        ram_sel_i = 4'hF; ram_data_i = '0;

        // Reset held with a live data request and a toggling ack.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_quiet("reset");
            extra_ack = ~extra_ack;
        end
        ram_ce_i = 1'b0; extra_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Fetch only, ack latency 2.
        req_q.push_back('{we: 1'b0, addr: 32'h10, sel: 4'hF, wdata: 32'h0});
        rsp_q.push_back('{rom: 32'h3401_1100, ram: 32'h0, err_n: 0, stall_n: 3, req_n: 3});
        access(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h10, 2);

        // Simultaneous load and fetch, latency 1 each: data first, one turnaround cycle.
        req_q.push_back('{we: 1'b0, addr: 32'h100, sel: 4'hF, wdata: 32'h0});
        req_q.push_back('{we: 1'b0, addr: 32'h14, sel: 4'hF, wdata: 32'h0});
        rsp_q.push_back('{rom: 32'h1234_5678, ram: 32'hCAFE_F00D, err_n: 0, stall_n: 5, req_n: 4});
        access(1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 1'b1, 32'h14, 1);

        // Store leaves ram_data_o untouched.
        req_q.push_back('{we: 1'b1, addr: 32'h200, sel: 4'h3, wdata: 32'hDEAD_BEEF});
        rsp_q.push_back('{rom: 32'h1234_5678, ram: 32'hCAFE_F00D, err_n: 0, stall_n: 3, req_n: 3});
        access(1'b1, 1'b1, 32'h200, 4'h3, 32'hDEAD_BEEF, 1'b0, 32'h0, 2);

        // Load with no ack times out after 4 cycles.
        req_q.push_back('{we: 1'b0, addr: 32'h400, sel: 4'hF, wdata: 32'h0});
        rsp_q.push_back('{rom: 32'h1234_5678, ram: 32'h0, err_n: 1, stall_n: 4, req_n: 4});
        access(1'b1, 1'b0, 32'h400, 4'hF, 32'h0, 1'b0, 32'h0, -1);

        // Reset mid data access, late ack arrives as reset is released.
        mem_lat = -1;
        req_q.push_back('{we: 1'b0, addr: 32'h300, sel: 4'hF, wdata: 32'h0});
        ram_ce_i = 1'b1; ram_we_i = 1'b0; ram_addr_i = 32'h300; ram_sel_i = 4'hF; ram_data_i = '0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #6;
        rst = 1'b1; extra_ack = 1'b1; ram_ce_i = 1'b0;
        @(posedge clk); #1;
        extra_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_quiet("late_ack");
        end
        chk("req_q_empty_rst", req_q.size(), 0);
        @(posedge clk); #1;

        // Recovery fetch after the aborted access.
        req_q.push_back('{we: 1'b0, addr: 32'h20, sel: 4'hF, wdata: 32'h0});
        rsp_q.push_back('{rom: 32'h0BAD_F00D, ram: 32'h0, err_n: 0, stall_n: 2, req_n: 2});
        access(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h20, 1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits between the openmips core's instruction-fetch port (rom_*) and data port (ram_*), and a single-ported memory with a req/ack handshake.
- Serialises the two ports onto the memory. The data port has priority.
- Holds the core with stallreq_o until every requested access has completed.
- Returns fetched instructions and load data through registered outputs.

Parameters:
ADDR_W, 32, address width of both core ports and the memory port
DATA_W, 32, data width
TIMEOUT, 255, max cycles to wait for mem_ack_i before aborting an access (8-bit counter)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
rom_ce_i  in  1  fetch request from core
rom_addr_i  in  ADDR_W  fetch address
rom_data_o  out  DATA_W  fetched instruction, registered
ram_ce_i  in  1  data-port request from core
ram_we_i  in  1  1 = store, 0 = load
ram_addr_i  in  ADDR_W  data address
ram_sel_i  in  4  byte enables
ram_data_i  in  DATA_W  store data
ram_data_o  out  DATA_W  load data, registered
stallreq_o  out  1  stall request to core pipeline control
err_o  out  1  one-cycle pulse on access timeout
mem_req_o  out  1  memory request, held until ack
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory address
mem_sel_o  out  4  memory byte enables (4'b1111 for fetch)
mem_wdata_o  out  DATA_W  memory write data
mem_rdata_i  in  DATA_W  memory read data, valid when mem_ack_i=1
mem_ack_i  in  1  memory completion, single-cycle pulse

Behaviour:
- Reset (rst=0 at a clock edge) drives the following values, and applies even mid-access:
  - rom_data_o=0, ram_data_o=0, stallreq_o=0, err_o=0.
  - All mem_* outputs = 0.
  - Timeout counter = 0; state = IDLE; pending flags cleared.
  - An abandoned memory transaction is dropped; any late ack is ignored.
- Core contract: while stallreq_o=1, the core holds all rom_*/ram_* inputs stable.
- Pending flags:
  - d_pend is set from ram_ce_i and i_pend from rom_ce_i.
  - Both are latched in IDLE on the first cycle either ce is 1.
- States:
  - IDLE:
    - If ram_ce_i=1: latch addr/we/sel/wdata, drive mem_req_o=1 next cycle, go D_ACC, stallreq_o=1.
    - Else if rom_ce_i=1: latch rom_addr_i, mem_we_o=0, mem_sel_o=4'b1111, go I_ACC, stallreq_o=1.
    - Else: stay in IDLE, stallreq_o=0.
  - D_ACC:
    - mem_req_o held at 1 with latched fields; the counter increments each cycle.
    - On mem_ack_i=1 with a load: ram_data_o <= mem_rdata_i. With a store: ram_data_o is unchanged.
    - After ack, drop mem_req_o the same edge; clear d_pend.
    - Then, if i_pend: go I_ACC, issuing the fetch on the next cycle. Else: go RELEASE.
  - I_ACC:
    - Same handshake as D_ACC. On ack, rom_data_o <= mem_rdata_i, clear i_pend, go RELEASE.
  - RELEASE:
    - stallreq_o=0 for exactly one cycle so the core advances.
    - No new access is sampled in this cycle; go IDLE.
- stallreq_o is registered:
  - 1 from the cycle after a request is sampled in IDLE through the ack cycle.
  - 0 in RELEASE and in idle IDLE.
- Latency:
  - A lone access with memory ack latency L cycles (ack L cycles after mem_req_o rises) gives stall for L+1 cycles, then the release cycle.
  - A simultaneous data+fetch request costs the sum of both accesses plus 1 turnaround cycle.
- Timeout:
  - If the counter reaches TIMEOUT with no ack: abort the current access (mem_req_o=0), pulse err_o for 1 cycle, write 0 to the destination output register (for loads/fetch), and continue as if acked.
  - The counter resets on every new access.
- mem_ack_i arriving in IDLE or RELEASE is ignored.
- An ack in the same cycle as a timeout counts as a normal ack; no err_o.

Test Plan:
1. rst=0 for 3 cycles with ram_ce_i=1 and mem_ack_i toggling -> all outputs 0, mem_req_o never asserted.
2. Fetch only: rom_addr_i=0x00000010, ack after 2 cycles with mem_rdata_i=0x34011100 -> mem_addr_o=0x10, mem_sel_o=4'hF, stallreq_o=1 for 3 cycles, then rom_data_o=0x34011100 and stallreq_o=0 for one cycle.
3. Simultaneous load addr 0x100 and fetch addr 0x14, ack latency 1 -> data access issued first, then fetch. ram_data_o and rom_data_o both updated. stallreq_o stays 1 continuously until RELEASE.
4. Store addr 0x200, sel 4'b0011, data 0xDEADBEEF -> mem_we_o=1, mem_sel_o=4'b0011, mem_wdata_o=0xDEADBEEF held until ack. ram_data_o unchanged.
5. TIMEOUT=4, load with no ack -> mem_req_o drops after 4 cycles, err_o pulses once, ram_data_o=0, RELEASE follows.
6. rst=0 asserted mid D_ACC, then deasserted while the old ack arrives -> state IDLE, ack ignored, no output update.
